// File: rtl/ib_queue_ctrl.sv
// Instruction-buffer queue between IF1 and decode: 0-4 pushes, up to 2 in-order pops per cycle.
// Optional performance counters are built when IB_PERF_CNT_EN is defined.
module ib_queue_ctrl #(
  parameter int DEPTH = 16,
  parameter int DW    = 82,
  parameter int LOG2  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [4*DW-1:0]   push_data,
  input  logic [2:0]        push_num,
  output logic [LOG2:0]     can_push_size,
  output logic [2*DW-1:0]   id_data,
  output logic [1:0]        id_valid,
  input  logic [1:0]        id_ready,
  output logic              overflow_err
`ifdef IB_PERF_CNT_EN
  ,
  output logic [31:0]       full_stall_cnt,
  output logic [31:0]       empty_cnt
`endif
);

  logic [DW-1:0]   mem [DEPTH];
  logic [LOG2-1:0] head;
  logic [LOG2-1:0] tail;
  logic [LOG2:0]   count;

  logic [LOG2+1:0] need;
  logic            push_ok;
  logic            do_push;
  logic            head_excp;
  logic            pop0;
  logic            pop1;
  logic [1:0]      pop_cnt;
  logic [LOG2:0]   push_add;
  logic [LOG2:0]   count_next;

`ifdef IB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  // One slot always stays free; the check uses the registered, pre-pop count.
  always_comb begin
    need      = {1'b0, count} + (LOG2+2)'(push_num);
    push_ok   = (need <= (LOG2+2)'(DEPTH - 1));
    do_push   = !flush && push_ok && (push_num != 3'd0);
    head_excp = mem[head][DW-3];

    id_valid[0] = (count != '0);
    id_valid[1] = (count >= (LOG2+1)'(2)) && !head_excp;
    id_data     = {mem[head + LOG2'(1)], mem[head]};

    pop0    = id_valid[0] & id_ready[0];
    pop1    = pop0 & id_valid[1] & id_ready[1];
    pop_cnt = {1'b0, pop0} + {1'b0, pop1};

    push_add   = do_push ? (LOG2+1)'(push_num) : '0;
    count_next = count + push_add - (LOG2+1)'(pop_cnt);
  end

  assign can_push_size = count;

  // Storage has no reset; only pointers and flags do.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (do_push && (3'(k) < push_num))
        mem[tail + LOG2'(k)] <= push_data[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + LOG2'(pop_cnt);
      count <= count_next;
      if (do_push)
        tail <= tail + LOG2'(push_num);
      if (!push_ok)
        overflow_err <= 1'b1;
    end
  end

`ifdef IB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      full_stall_cnt <= '0;
      empty_cnt      <= '0;
    end else begin
      if ((push_num != 3'd0) && !push_ok)
        full_stall_cnt <= sat_inc(full_stall_cnt);
      if (count == '0)
        empty_cnt <= sat_inc(empty_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_ib_queue_ctrl.sv
// Bench for ib_queue_ctrl: directed vector table, hand sequences, and randomized traffic vs a queue model.
module tb_ib_queue_ctrl;
  localparam int DEPTH = 16;
  localparam int DW    = 82;
  localparam int LOG2  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [4*DW-1:0] push_data;
  logic [2:0]      push_num;
  logic [LOG2:0]   can_push_size;
  logic [2*DW-1:0] id_data;
  logic [1:0]      id_valid;
  logic [1:0]      id_ready;
  logic            overflow_err;
`ifdef IB_PERF_CNT_EN
  logic [31:0]     full_stall_cnt;
  logic [31:0]     empty_cnt;
`endif

  always #5 clk = ~clk;

  ib_queue_ctrl #(.DEPTH(DEPTH), .DW(DW), .LOG2(LOG2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_data(push_data), .push_num(push_num),
    .can_push_size(can_push_size), .id_data(id_data), .id_valid(id_valid),
    .id_ready(id_ready), .overflow_err(overflow_err)
`ifdef IB_PERF_CNT_EN
    , .full_stall_cnt(full_stall_cnt), .empty_cnt(empty_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_ovf;
  longint        m_stall;
  longint        m_empty;
  int            excp_pct;

  function automatic logic [DW-1:0] mk_entry(input bit excp);
    logic [DW-1:0] e;
    e = {1'b1, 1'($urandom), excp, 6'($urandom), 9'($urandom), 32'($urandom), 32'($urandom)};
    return e;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic check_model();
    logic [1:0] ev;
    ev[0] = (q.size() >= 1);
    ev[1] = (q.size() >= 2) && !q[0][DW-3];
    chk("count", DW'(can_push_size), DW'(q.size()));
    chk("id_valid", DW'(id_valid), DW'(ev));
    chk("overflow_err", DW'(overflow_err), DW'(m_ovf));
    if (ev[0]) chk("id_data0", id_data[DW-1:0], q[0]);
    if (ev[1]) chk("id_data1", id_data[2*DW-1:DW], q[1]);
`ifdef IB_PERF_CNT_EN
    chk("full_stall_cnt", DW'(full_stall_cnt), DW'(m_stall));
    chk("empty_cnt", DW'(empty_cnt), DW'(m_empty));
`endif
  endtask

  // Starts and ends at a negedge; builds random lane data, applies, advances the model.
  task automatic do_cycle(input int pn, input logic [1:0] rdy, input bit fl, input bit excp0);
    logic [DW-1:0] lanes[4];
    int  npop;
    bit  legal;
    for (int k = 0; k < 4; k++) begin
      lanes[k] = mk_entry((k == 0) ? excp0 : ($urandom_range(99) < excp_pct));
      push_data[k*DW +: DW] = lanes[k];
    end
    push_num = 3'(pn);
    id_ready = rdy;
    flush    = fl;
    npop = 0;
    if (q.size() >= 1 && rdy[0]) begin
      npop = 1;
      if (q.size() >= 2 && !q[0][DW-3] && rdy[1]) npop = 2;
    end
    legal = (q.size() + pn <= DEPTH - 1);
    if (q.size() == 0) m_empty++;
    if (pn != 0 && !legal) m_stall++;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      for (int i = 0; i < npop; i++) void'(q.pop_front());
      if (legal) for (int k = 0; k < pn; k++) q.push_back(lanes[k]);
      else m_ovf = 1'b1;
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; push_num = '0; id_ready = '0; push_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete(); m_ovf = 1'b0; m_stall = 0; m_empty = 0;
    check_model();
  endtask

  typedef struct {
    int         pn;
    logic [1:0] rdy;
    bit         fl;
    int         exp_count;
    logic [1:0] exp_valid;
    bit         exp_ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    excp_pct = 0;
    vecs[0] = '{4, 2'b00, 0, 4,  2'b11, 0};
    vecs[1] = '{4, 2'b00, 0, 8,  2'b11, 0};
    vecs[2] = '{4, 2'b00, 0, 12, 2'b11, 0};
    vecs[3] = '{4, 2'b00, 0, 12, 2'b11, 1};  // 12+4 > 15: rejected
    vecs[4] = '{0, 2'b10, 0, 12, 2'b11, 1};  // lane 1 cannot pop alone
    vecs[5] = '{3, 2'b11, 1, 0,  2'b00, 1};  // flush beats push and pop
    vecs[6] = '{2, 2'b00, 0, 2,  2'b11, 1};
    vecs[7] = '{1, 2'b01, 0, 2,  2'b11, 1};
    vecs[8] = '{0, 2'b11, 0, 0,  2'b00, 1};

    do_reset();
    chk("rst_count", DW'(can_push_size), '0);
    chk("rst_valid", DW'(id_valid), '0);
    chk("rst_ovf", DW'(overflow_err), '0);

    for (int i = 0; i < 9; i++) begin
      do_cycle(vecs[i].pn, vecs[i].rdy, vecs[i].fl, 1'b0);
      chk($sformatf("vec%0d_count", i), DW'(can_push_size), DW'(vecs[i].exp_count));
      chk($sformatf("vec%0d_valid", i), DW'(id_valid), DW'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_ovf", i), DW'(overflow_err), DW'(vecs[i].exp_ovf));
    end

    // Wrap: reach 14 with the tail wrapped, then push 1 and pop 2 together.
    do_reset();
    do_cycle(4, 2'b11, 0, 0);
    do_cycle(4, 2'b11, 0, 0);
    do_cycle(4, 2'b11, 0, 0);
    chk("wrap_count8", DW'(can_push_size), DW'(8));
    do_cycle(4, 2'b00, 0, 0);
    do_cycle(2, 2'b00, 0, 0);
    chk("wrap_count14", DW'(can_push_size), DW'(14));
    do_cycle(1, 2'b11, 0, 0);
    chk("wrap_count13", DW'(can_push_size), DW'(13));
    chk("wrap_ovf", DW'(overflow_err), '0);
    for (int i = 0; i < 7; i++) do_cycle(0, 2'b11, 0, 0);
    chk("wrap_drained", DW'(can_push_size), '0);

    // Excepting head entry issues alone.
    do_reset();
    do_cycle(3, 2'b00, 0, 1);
    chk("excp_count3", DW'(can_push_size), DW'(3));
    chk("excp_valid", DW'(id_valid), DW'(2'b01));
    do_cycle(0, 2'b11, 0, 0);
    chk("excp_count2", DW'(can_push_size), DW'(2));

`ifdef IB_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 10; i++) do_cycle(0, 2'b00, 0, 0);
    chk("perf_empty10", DW'(empty_cnt), DW'(10));
    for (int i = 0; i < 3; i++) do_cycle(4, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) do_cycle(4, 2'b00, 0, 0);
    chk("perf_stall3", DW'(full_stall_cnt), DW'(3));
    chk("perf_empty11", DW'(empty_cnt), DW'(11));
`endif

    // Randomized traffic against the queue model.
    do_reset();
    excp_pct = 25;
    for (int i = 0; i < 3000; i++) begin
      int pn;
      pn = $urandom_range(4);
      if (i % 500 == 250) begin
        do_reset();
      end
      do_cycle(pn, 2'($urandom), ($urandom_range(99) < 3), ($urandom_range(99) < 25));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
